// File: rtl/cobra_pkg.sv
// Shared types for the video RAM arbiter: read FSM states and per-cycle grant codes.
package cobra_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD,
    ARB_ACK
  } arb_state_t;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_VID,
    GNT_WB,
    GNT_CPURD,
    GNT_CPU_FORCED
  } grant_t;

  // True for any grant that gives the RAM slot to the CPU side.
  function automatic logic is_cpu_grant(grant_t g);
    return (g == GNT_WB) || (g == GNT_CPURD) || (g == GNT_CPU_FORCED);
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module wbuf_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one synchronous VRAM port between video fetch and a CPU served through
// a posted-write buffer, a read FSM and a starvation-bounded forced slot.
module vram_arbiter
  import cobra_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_a,
  output logic [DATA_W-1:0] vid_q,
  output logic              vid_valid,
  output logic              vid_miss,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              wbuf_empty
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam int unsigned SC_W  = $clog2(STARVE_LIM + 1);

  arb_state_t        state;
  grant_t            grant;
  logic [SC_W-1:0]   starve;
  logic [1:0]        rd_cnt;
  logic [RD_LAT-1:0] vid_pipe;

  logic              wb_full;
  logic              wb_empty;
  logic [ENT_W-1:0]  wb_head;
  logic              wb_pop;
  logic              rd_pend;
  logic              rd_issue;
  logic              wr_accept;
  logic              cpu_pend;
  logic              starved;

  // A read only counts as pending while the FSM is idle and not acking.
  assign rd_pend   = cpu_req & ~cpu_we & ~cpu_ack & (state == ARB_IDLE);
  assign wr_accept = cpu_req & cpu_we & ~cpu_ack & ~wb_full & (state == ARB_IDLE);
  assign cpu_pend  = ~wb_empty | rd_pend;
  assign starved   = (starve == SC_W'(STARVE_LIM));

  always_comb begin
    grant = GNT_NONE;
    if (rst) begin
      grant = GNT_NONE;
    end else if (cpu_pend && starved) begin
      grant = GNT_CPU_FORCED;
    end else if (vid_req) begin
      grant = GNT_VID;
    end else if (!wb_empty) begin
      grant = GNT_WB;
    end else if (rd_pend) begin
      grant = GNT_CPURD;
    end
  end

  // Forced slots drain the buffer first so reads never pass older writes.
  assign wb_pop   = (grant == GNT_WB) || ((grant == GNT_CPU_FORCED) && !wb_empty);
  assign rd_issue = (grant == GNT_CPURD) || ((grant == GNT_CPU_FORCED) && wb_empty);

  always_comb begin
    ram_a  = vid_a;
    ram_d  = wb_head[DATA_W-1:0];
    ram_we = 1'b0;
    if (wb_pop) begin
      ram_a  = wb_head[ENT_W-1:DATA_W];
      ram_we = 1'b1;
    end else if (rd_issue) begin
      ram_a = cpu_a;
    end
  end

  assign cpu_wait_n = ~(cpu_req & ~cpu_ack);
  assign vid_q      = ram_q;
  assign vid_valid  = vid_pipe[RD_LAT-1];
  assign wbuf_empty = wb_empty;

  wbuf_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_accept),
    .push_data ({cpu_a, cpu_d}),
    .pop       (wb_pop),
    .head      (wb_head),
    .full      (wb_full),
    .empty     (wb_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
    end else if (!cpu_pend || is_cpu_grant(grant)) begin
      starve <= '0;
    end else if ((grant == GNT_VID) && !starved) begin
      starve <= starve + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      rd_cnt  <= '0;
      cpu_ack <= 1'b0;
      cpu_q   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (wr_accept) cpu_ack <= 1'b1;
          if (rd_issue) begin
            state  <= ARB_RD;
            rd_cnt <= '0;
          end
        end
        ARB_RD: begin
          if (rd_cnt == 2'(RD_LAT - 1)) begin
            cpu_q   <= ram_q;
            cpu_ack <= 1'b1;
            state   <= ARB_ACK;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        ARB_ACK: state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_pipe <= '0;
      vid_miss <= 1'b0;
    end else begin
      vid_pipe[0] <= (grant == GNT_VID);
      for (int i = 1; i < RD_LAT; i++) vid_pipe[i] <= vid_pipe[i-1];
      vid_miss <= vid_req & (grant == GNT_CPU_FORCED);
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural RAM, event-scheduled reference model,
// and directed CPU/video scenarios with hand-computed latencies and data.
module tb_vram_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int RDL   = 2;
  localparam int SLIM  = 8;
  localparam int NC    = 4096;

  localparam int G_NONE  = 0;
  localparam int G_VID   = 1;
  localparam int G_WB    = 2;
  localparam int G_RD    = 3;
  localparam int G_FORCE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_a = '0;
  logic [DW-1:0] cpu_d = '0;
  logic [DW-1:0] cpu_q;
  logic          cpu_ack;
  logic          cpu_wait_n;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_a = '0;
  logic [DW-1:0] vid_q;
  logic          vid_valid;
  logic          vid_miss;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          wbuf_empty;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WBUF_DEPTH (DEPTH),
    .RD_LAT     (RDL),
    .STARVE_LIM (SLIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_a      (cpu_a),
    .cpu_d      (cpu_d),
    .cpu_q      (cpu_q),
    .cpu_ack    (cpu_ack),
    .cpu_wait_n (cpu_wait_n),
    .vid_req    (vid_req),
    .vid_a      (vid_a),
    .vid_q      (vid_q),
    .vid_valid  (vid_valid),
    .vid_miss   (vid_miss),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .ram_q      (ram_q),
    .wbuf_empty (wbuf_empty)
  );

  // Behavioural VRAM, read-first, RD_LAT = 2 output pipeline.
  logic [DW-1:0] ram_mem [2048];
  logic [DW-1:0] ram_s1;
  logic [DW-1:0] ram_s2;
  always @(posedge clk) begin
    ram_s1 <= ram_mem[ram_a];
    ram_s2 <= ram_s1;
    if (ram_we) ram_mem[ram_a] <= ram_d;
  end
  assign ram_q = ram_s2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Video fetch source: one fetch per cycle at 0x000..0x00F while enabled.
  bit vid_on = 1'b0;
  int vid_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (vid_on) begin
      vid_req = 1'b1;
      vid_a   = AW'(vid_cnt);
      vid_cnt = (vid_cnt + 1) % 16;
    end else begin
      vid_req = 1'b0;
      vid_cnt = 0;
    end
  end

  // Reference model: buffer as a queue, memory image, events scheduled by cycle number.
  logic [AW+DW-1:0] mq[$];
  logic [DW-1:0]    mmem [2048];
  int               starve = 0;
  bit               rd_busy = 1'b0;
  bit               exp_ack  [NC];
  bit               exp_isrd [NC];
  logic [DW-1:0]    exp_rdq  [NC];
  bit               exp_vv   [NC];
  logic [DW-1:0]    exp_vq   [NC];
  bit               exp_miss [NC];
  logic [DW-1:0]    cur_q = '0;

  always @(negedge clk) begin : model
    bit               ack_now;
    bit               rdp;
    bit               wacc;
    bit               pend;
    bit               drain;
    bit               issue;
    int               g;
    logic [AW-1:0]    ea;
    logic [AW+DW-1:0] hd;

    ack_now = exp_ack[cyc];
    if (ack_now && exp_isrd[cyc]) cur_q = exp_rdq[cyc];
    check("cpu_ack", cpu_ack, ack_now);
    check("cpu_q", cpu_q, cur_q);
    check("vid_valid", vid_valid, exp_vv[cyc]);
    if (exp_vv[cyc]) check("vid_q", vid_q, exp_vq[cyc]);
    check("vid_miss", vid_miss, exp_miss[cyc]);
    check("wbuf_empty", wbuf_empty, mq.size() == 0);
    check("cpu_wait_n", cpu_wait_n, !(cpu_req && !ack_now));
    if (ack_now && exp_isrd[cyc]) rd_busy = 1'b0;

    g = G_NONE; drain = 1'b0; issue = 1'b0; wacc = 1'b0; pend = 1'b0; hd = '0;
    if (!rst) begin
      rdp  = cpu_req && !cpu_we && !ack_now && !rd_busy;
      wacc = cpu_req && cpu_we && !ack_now && !rd_busy && (mq.size() < DEPTH);
      pend = (mq.size() > 0) || rdp;
      if (pend && starve >= SLIM) g = G_FORCE;
      else if (vid_req)           g = G_VID;
      else if (mq.size() > 0)     g = G_WB;
      else if (rdp)               g = G_RD;
      if (mq.size() > 0) hd = mq[0];
      drain = (g == G_WB) || (g == G_FORCE && mq.size() > 0);
      issue = (g == G_RD) || (g == G_FORCE && mq.size() == 0);
    end

    ea = drain ? hd[AW+DW-1:DW] : (issue ? cpu_a : vid_a);
    check("ram_we", ram_we, drain);
    check("ram_a", ram_a, ea);
    if (drain) check("ram_d", ram_d, hd[DW-1:0]);

    if (rst) begin
      mq.delete();
      starve  = 0;
      rd_busy = 1'b0;
      for (int j = cyc + 1; j <= cyc + RDL + 2; j++) begin
        exp_ack[j] = 1'b0; exp_isrd[j] = 1'b0; exp_vv[j] = 1'b0; exp_miss[j] = 1'b0;
      end
      cur_q = '0;
    end else begin
      if (g == G_VID) begin
        exp_vv[cyc+RDL] = 1'b1;
        exp_vq[cyc+RDL] = mmem[vid_a];
      end
      if (g == G_FORCE && vid_req) exp_miss[cyc+1] = 1'b1;
      if (issue) begin
        rd_busy = 1'b1;
        exp_ack[cyc+RDL+1]  = 1'b1;
        exp_isrd[cyc+RDL+1] = 1'b1;
        exp_rdq[cyc+RDL+1]  = mmem[cpu_a];
      end
      if (wacc) begin
        exp_ack[cyc+1]  = 1'b1;
        exp_isrd[cyc+1] = 1'b0;
      end
      if (!pend || g == G_WB || g == G_RD || g == G_FORCE) starve = 0;
      else if (g == G_VID && starve < SLIM) starve++;
      if (drain) begin
        mmem[hd[AW+DW-1:DW]] = hd[DW-1:0];
        void'(mq.pop_front());
      end
      if (wacc) mq.push_back({cpu_a, cpu_d});
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one access from the next cycle and holds it until cpu_ack is seen.
  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output logic [DW-1:0] q, output int misses,
                            output int wes);
    bit got;
    step();
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_d = d;
    lat = 0; misses = 0; wes = 0; got = 1'b0; q = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (vid_miss) misses++;
      if (ram_we) wes++;
      if (cpu_ack) begin
        got = 1'b1;
        q   = cpu_q;
        break;
      end
      lat++;
    end
    if (!got) check("ack_timeout", got, 1);
  endtask

  task automatic cpu_idle();
    step();
    cpu_req = 1'b0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int            lat;
    int            ms;
    int            wn;
    int            nv;
    int            nm;
    int            cnt_we;
    int            cnt_ack;
    logic [DW-1:0] q;
    logic [DW-1:0] vq[$];

    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = i[7:0] ^ 8'hA5;
      mmem[i]    = i[7:0] ^ 8'hA5;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read back with idle video.
    cpu_access(1'b1, 11'h123, 8'h5A, lat, q, ms, wn);
    check("t1_wr_lat", lat, 1);
    cpu_access(1'b0, 11'h123, 8'h00, lat, q, ms, wn);
    check("t1_rd_lat", lat, 3);
    check("t1_rd_q", q, 8'h5A);
    cpu_idle();
    repeat (3) step();

    // Five back-to-back writes under continuous video: fifth waits for a forced drain.
    vid_on = 1'b1;
    repeat (2) step();
    for (int w = 0; w < 5; w++) begin
      cpu_access(1'b1, AW'(11'h300 + w), DW'(8'hC0 + w), lat, q, ms, wn);
      if (w < 4) check("t2_wr_lat", lat, 1);
      else begin
        check("t2_wr5_lat", lat, 3);
        check("t2_wr5_miss", ms, 1);
      end
    end
    cpu_idle();
    vid_on = 1'b0;
    repeat (8) step();
    check("t2_drained", wbuf_empty, 1);

    // Read behind three buffered writes returns the youngest data for that address.
    vid_on = 1'b1;
    repeat (2) step();
    cpu_access(1'b1, 11'h040, 8'h11, lat, q, ms, wn);
    check("t3_wr_lat", lat, 1);
    cpu_access(1'b1, 11'h041, 8'h22, lat, q, ms, wn);
    cpu_access(1'b1, 11'h040, 8'h33, lat, q, ms, wn);
    vid_on = 1'b0;
    cpu_access(1'b0, 11'h040, 8'h00, lat, q, ms, wn);
    check("t3_rd_lat", lat, 6);
    check("t3_rd_q", q, 8'h33);
    check("t3_drains", wn, 3);
    cpu_idle();
    repeat (3) step();

    // Sixteen video fetches with no CPU traffic.
    vid_on = 1'b1;
    nv = 0; nm = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (vid_valid) begin
        nv++;
        vq.push_back(vid_q);
      end
      if (vid_miss) nm++;
      if (k == 15) vid_on = 1'b0;
    end
    check("t4_valid_cnt", nv, 16);
    check("t4_miss_cnt", nm, 0);
    if (vq.size() == 16) begin
      check("t4_first_q", vq[0], 8'hA5);
      check("t4_last_q", vq[15], 8'hAA);
    end
    step();

    // Reset with two buffered writes and a waiting read.
    vid_on = 1'b1;
    repeat (2) step();
    cpu_access(1'b1, 11'h050, 8'h77, lat, q, ms, wn);
    cpu_access(1'b1, 11'h051, 8'h88, lat, q, ms, wn);
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 11'h050;
    @(negedge clk);
    check("t5_pre_full", wbuf_empty, 0);
    step();
    rst = 1'b1; cpu_req = 1'b0; vid_on = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_empty", wbuf_empty, 1);
    check("t5_ack", cpu_ack, 0);
    check("t5_vvalid", vid_valid, 0);
    cnt_we = 0; cnt_ack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ram_we) cnt_we++;
      if (cpu_ack) cnt_ack++;
    end
    check("t5_no_we", cnt_we, 0);
    check("t5_no_ack", cnt_ack, 0);

    // Reset while a read is in flight: no acknowledge, cpu_q cleared.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 11'h123;
    @(negedge clk);
    step();
    rst = 1'b1; cpu_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_cpu_q", cpu_q, 0);
    cnt_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ack) cnt_ack++;
    end
    check("t6_no_ack", cnt_ack, 0);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
